// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage and its neighbours.
//   fetch_state_e : fetch FSM states
//   NOP_INSTR     : canonical NOP (addi x0,x0,0) presented after reset
//   OPCODE_*      : major opcodes, shared with the control unit
package instr_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus.
//   imem_req   : fetch request, level, held until imem_valid
//   imem_addr  : word-aligned fetch address, stable while a request is open
//   imem_rdata : returned instruction word
//   imem_valid : one-cycle response strobe per request
// master = fetch stage, slave = instruction memory.
interface instr_fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection for the fetch stage.
//   pc_i         : current PC (always word aligned)
//   pc_sel_i     : 1 = branch/jump target, 0 = sequential
//   alu_target_i : branch/jump target
//   flush_i      : redirect, takes priority over pc_sel_i
//   flush_pc_i   : redirect address
//   next_pc_o    : selected address with bits [1:0] cleared
//   pc_plus4_o   : pc_i + 4, wraps modulo 2^XLEN
//   misalign_o   : selected address had non-zero bits [1:0]
module pc_next #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_sel_i,
    input  logic [XLEN-1:0] alu_target_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] target_raw;

    always_comb begin
        pc_plus4_o = pc_i + XLEN'(4);
        if (flush_i) begin
            target_raw = flush_pc_i;
        end else if (pc_sel_i) begin
            target_raw = alu_target_i;
        end else begin
            target_raw = pc_plus4_o;
        end
        // pc_i is aligned, so only an external target can trip misalign
        next_pc_o  = {target_raw[XLEN-1:2], 2'b00};
        misalign_o = |target_raw[1:0];
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, fetches words over the imem handshake and
// presents a stable instruction to the control unit until it is consumed.
//   clk, rst_n     : clock, synchronous active-low reset
//   pc_sel         : 1 = next PC is alu_target, 0 = pc + 4
//   alu_target     : branch/jump target
//   stall          : downstream not ready to consume instr
//   flush/flush_pc : redirect request and address
//   imem           : instruction-memory bus (master side)
//   instr          : current instruction
//   instr_valid    : instr holds a fetched, unconsumed word
//   pc, pc_plus4   : address of instr and its sequential successor
//   misalign       : one-cycle pulse when a target had bits [1:0] != 0
//   illegal        : valid instruction whose bits [1:0] are not 2'b11
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] alu_target,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    instr_fetch_if.master   imem,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign,
    output logic            illegal
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] instr_q;
    logic            instr_valid_q;
    logic            req_q;
    logic            drop_q;
    logic            misalign_q;

    logic [XLEN-1:0] next_pc;
    logic            next_misalign;

    pc_next #(
        .XLEN (XLEN)
    ) u_pc_next (
        .pc_i         (pc_q),
        .pc_sel_i     (pc_sel),
        .alu_target_i (alu_target),
        .flush_i      (flush),
        .flush_pc_i   (flush_pc),
        .next_pc_o    (next_pc),
        .pc_plus4_o   (pc_plus4),
        .misalign_o   (next_misalign)
    );

    // addr_q is kept apart from pc_q so that a flush during an open request
    // can update the PC without disturbing the address the memory is serving.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            instr_q       <= XLEN'(NOP_INSTR);
            instr_valid_q <= 1'b0;
            req_q         <= 1'b0;
            drop_q        <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (flush) begin
                pc_q          <= next_pc;
                misalign_q    <= next_misalign;
                instr_valid_q <= 1'b0;
                case (state_q)
                    FETCH: begin
                        if (imem.imem_valid) begin
                            // response arrives with the flush: discard it, re-request
                            drop_q <= 1'b0;
                            addr_q <= next_pc;
                        end else begin
                            // response still owed: swallow it before re-requesting
                            drop_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= next_pc;
                        drop_q  <= 1'b0;
                    end
                endcase
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                    FETCH: begin
                        if (imem.imem_valid) begin
                            if (drop_q) begin
                                drop_q <= 1'b0;
                                addr_q <= pc_q;
                            end else begin
                                instr_q       <= imem.imem_rdata;
                                instr_valid_q <= 1'b1;
                                req_q         <= 1'b0;
                                state_q       <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        if (!stall) begin
                            pc_q          <= next_pc;
                            misalign_q    <= next_misalign;
                            instr_valid_q <= 1'b0;
                            addr_q        <= next_pc;
                            req_q         <= 1'b1;
                            state_q       <= FETCH;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign misalign    = misalign_q;
    assign illegal     = instr_valid_q && (instr_q[1:0] != 2'b11);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic.
// Expected issue addresses are queued by the stimulus side; a monitor pops
// and compares whenever a new instruction becomes valid.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_sel;
    logic [31:0] alu_target;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic        illegal;

    instr_fetch_if #(.XLEN(32)) imem_bus ();

    instr_fetch #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_sel      (pc_sel),
        .alu_target  (alu_target),
        .stall       (stall),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .imem        (imem_bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign),
        .illegal     (illegal)
    );

    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RST_PC;
    logic        exp_mis = 1'b0;
    bit          mon_on = 1'b0;
    int          mem_mode = 0;
    bit          mem_rand = 1'b0;
    int unsigned mem_delay = 0;
    logic [31:0] last_req_addr = '0;
    bit          spacing_on = 1'b0;
    int          last_issue_cyc = -1;
    int          issued = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Memory contents: mode 0 all NOP, mode 1 address hash (some illegal), mode 2 all zero
    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] h;
        if (mem_mode == 0) return NOP;
        if (mem_mode == 2) return 32'h0;
        h = (a * 32'h9E37_79B1) ^ 32'h1234_5670;
        if (a[4:2] != 3'b000) h[1:0] = 2'b11;
        return h;
    endfunction

    // Instruction memory: response arrives (delay + 1) cycles after a request is seen
    initial begin
        logic        pend;
        int unsigned cnt;
        logic [31:0] a_l;
        pend = 1'b0;
        cnt  = 0;
        a_l  = '0;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                imem_bus.imem_valid = 1'b0;
                pend = 1'b0;
            end else if (imem_bus.imem_valid) begin
                imem_bus.imem_valid = 1'b0;
            end else if (pend) begin
                chk("addr_stable", imem_bus.imem_addr, a_l);
                chk("req_held", {31'b0, imem_bus.imem_req}, 32'd1);
                if (cnt == 0) begin
                    imem_bus.imem_valid = 1'b1;
                    imem_bus.imem_rdata = word(a_l);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (imem_bus.imem_req === 1'b1) begin
                a_l = imem_bus.imem_addr;
                last_req_addr = a_l;
                pend = 1'b1;
                cnt = mem_rand ? $urandom_range(0, 4) : mem_delay;
                chk("addr_aligned", {30'b0, a_l[1:0]}, 32'd0);
            end
        end
    end

    // Monitor: sampled 1 time unit after each rising edge
    initial begin
        logic        prev_v;
        logic [31:0] prev_i, prev_p, e, w;
        prev_v = 1'b0;
        prev_i = '0;
        prev_p = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mon_on) begin
                chk("misalign", {31'b0, misalign}, {31'b0, exp_mis});
                if (instr_valid && !prev_v) begin
                    issued++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL issue_unexpected: got pc %h expected no issue", pc);
                    end else begin
                        e = exp_q.pop_front();
                        w = word(e);
                        chk("issue_pc", pc, e);
                        chk("issue_instr", instr, w);
                        chk("pc_plus4", pc_plus4, e + 32'd4);
                        chk("illegal", {31'b0, illegal}, {31'b0, (w[1:0] != 2'b11)});
                    end
                    if (spacing_on) begin
                        if (last_issue_cyc >= 0) chk("issue_spacing", 32'(cyc - last_issue_cyc), 32'd3);
                        last_issue_cyc = cyc;
                    end
                end else if (instr_valid) begin
                    chk("hold_instr", instr, prev_i);
                    chk("hold_pc", pc, prev_p);
                    chk("req_in_issue", {31'b0, imem_bus.imem_req}, 32'd0);
                end
            end
            exp_mis = 1'b0;
            prev_v = instr_valid;
            prev_i = instr;
            prev_p = pc;
        end
    end

    // One negedge of stimulus; updates the expected-issue queue from the PC rules
    task automatic drive(input bit fl, input logic [31:0] fpc, input bit st, input bit sel, input logic [31:0] tgt);
        @(negedge clk);
        flush      = fl;
        flush_pc   = fpc;
        stall      = st;
        pc_sel     = sel;
        alu_target = tgt;
        if (fl) begin
            model_pc = {fpc[31:2], 2'b00};
            exp_q.delete();
            exp_q.push_back(model_pc);
            exp_mis = (fpc[1:0] != 2'b00);
        end else if (instr_valid && !st) begin
            model_pc = sel ? {tgt[31:2], 2'b00} : model_pc + 32'd4;
            exp_q.push_back(model_pc);
            exp_mis = sel && (tgt[1:0] != 2'b00);
        end
    endtask

    task automatic hold();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
    endtask

    task automatic consume(input bit sel, input logic [31:0] tgt);
        drive(1'b0, '0, 1'b0, sel, tgt);
    endtask

    task automatic wait_issue();
        int unsigned n;
        n = 0;
        do begin
            hold();
            n++;
        end while (!instr_valid && n < 100);
        checks++;
        if (!instr_valid) begin
            failures++;
            $display("FAIL wait_issue: got instr_valid=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic do_reset(input int mode);
        @(negedge clk);
        rst_n    = 1'b0;
        flush    = 1'b0;
        stall    = 1'b1;
        mem_mode = mode;
        exp_q.delete();
        model_pc = RST_PC;
        exp_q.push_back(RST_PC);
        @(posedge clk);
        #1;
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, NOP);
        chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        mon_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued_before;
        rst_n      = 1'b0;
        stall      = 1'b1;
        flush      = 1'b0;
        pc_sel     = 1'b0;
        alu_target = '0;
        flush_pc   = '0;

        // Zero-wait NOP memory: sequential fetch, one issue every 3 cycles
        mem_delay = 0;
        do_reset(0);
        spacing_on = 1'b1;
        last_issue_cyc = -1;
        repeat (16) consume(1'b0, '0);
        spacing_on = 1'b0;

        // Stall held for 5 cycles in ISSUE
        do_reset(1);
        wait_issue();
        repeat (5) hold();
        consume(1'b0, '0);

        // Taken branch to 0x10, then misaligned target 0x42 -> 0x40
        wait_issue();
        consume(1'b1, 32'h0000_0010);
        wait_issue();
        consume(1'b1, 32'h0000_0042);
        wait_issue();
        chk("branch_fetch_addr", last_req_addr, 32'h0000_0040);

        // Slow memory, flush while a request is open
        mem_delay = 4;
        consume(1'b0, '0);
        hold();
        hold();
        drive(1'b1, 32'h0000_0100, 1'b1, 1'b0, '0);
        wait_issue();
        chk("flush_fetch_addr", last_req_addr, 32'h0000_0100);
        mem_delay = 0;

        // Sequential wrap at the top of the address space
        consume(1'b1, 32'hFFFF_FFFC);
        wait_issue();
        consume(1'b0, '0);
        wait_issue();
        chk("wrap_fetch_addr", last_req_addr, 32'h0000_0000);

        // Reset during FETCH, then during ISSUE, then all-zero memory
        consume(1'b0, '0);
        do_reset(1);
        wait_issue();
        do_reset(2);
        wait_issue();
        chk("illegal_zero_word", {31'b0, illegal}, 32'd1);

        // Randomized traffic with random memory latency
        do_reset(1);
        mem_rand = 1'b1;
        issued_before = issued;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                drive(1'b1, $urandom, 1'b0, 1'b0, '0);
            end else begin
                drive(1'b0, '0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), $urandom);
            end
        end
        hold();
        checks++;
        if (issued - issued_before < 50) begin
            failures++;
            $display("FAIL random_progress: got %0d issues expected at least 50", issued - issued_before);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
